test_status_collector: RTL and testbench
========================================

Name: test_status_collector

Overview:
- Consumer end of the per-test fail/finish interface that every self-checking test harness in the CI suite exposes.
- Drives the harness resets and sequences the run.
- Collects sticky fail and finish flags from NUM_TESTS harnesses and enforces a cycle-budget watchdog.
- Produces one latched pass/fail/timeout verdict for the top-level simulation driver.

Parameters:
- NUM_TESTS, 4, number of harnesses attached; bit i of every vector port belongs to harness i.
- RESET_CYCLES, 2, cycles test_reset is held high after the collector leaves reset; minimum 1.
- TIMEOUT, 1024, maximum RUN cycles before the watchdog fires; minimum 2.
- CW, 32, width of the cycle counter.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- test_fail  in  NUM_TESTS  fail outputs of the harnesses.
- test_finish  in  NUM_TESTS  finish outputs of the harnesses.
- test_reset  out  1  active-high reset to all harnesses.
- done  out  1  verdict valid; sticky until reset.
- pass  out  1  done and no failure and no timeout.
- fail  out  1  any harness failed, or timeout.
- timeout  out  1  watchdog fired before all harnesses finished.
- fail_mask  out  NUM_TESTS  sticky per-harness fail bits.
- finish_mask  out  NUM_TESTS  sticky per-harness finish bits.
- cycles  out  CW  RUN cycles elapsed; saturates at all-ones.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at posedge) applies these values:
  - test_reset=1.
  - done=0, pass=0, fail=0, timeout=0.
  - fail_mask=0, finish_mask=0, cycles=0.
  - State=HOLD, hold counter=0.
- Reset asserted in any state, including mid-RUN or DONE, returns to exactly these values on that edge.
- HOLD:
  - test_reset=1; hold counter increments each cycle.
  - After RESET_CYCLES cycles in HOLD, go to RUN; test_reset=0 from the first RUN cycle.
  - test_fail and test_finish are ignored in HOLD.
- RUN:
  - Each cycle: fail_mask |= test_fail; finish_mask |= test_finish; cycles += 1, saturating.
  - A fail and a finish from the same harness in the same cycle are both captured.
  - Completion is evaluated on the updated masks, i.e. finish_mask | test_finish.
  - If all NUM_TESTS bits are set, go to DONE next cycle with timeout=0.
  - Otherwise, if cycles == TIMEOUT-1 in this cycle, go to DONE with timeout=1.
  - If completion and watchdog coincide, completion wins and timeout=0.
- DONE:
  - done=1.
  - fail = (fail_mask != 0) | timeout.
  - pass = ~fail.
  - test_reset=1, re-asserted to quiesce the harnesses.
  - Masks and cycles are frozen; fail and finish inputs are ignored.
  - Holds until reset.
- Latency:
  - done rises exactly one cycle after the RUN cycle in which the final finish bit arrives.
  - First RUN cycle is RESET_CYCLES cycles after reset deasserts.
- pass and fail are 0 whenever done=0.
- The harnesses' own reset is active-high; the collector performs the polarity translation.

Optional Feature:
- Macro: FAIL_FAST_EN.
- Defined:
  - In RUN, any nonzero test_fail moves to DONE next cycle regardless of finish state, with fail=1 and timeout=0.
  - fail_mask holds all bits seen up to and including that cycle.
  - Fail-fast takes priority over completion and watchdog in the same cycle.
- Undefined:
  - Failures are only accumulated; the run continues until all harnesses finish or the watchdog fires.

Test Plan:
- Reset low 3 cycles, then high; drive fail=0000 and finish=0000 -> test_reset=1 for 2 cycles then 0, done=0, cycles increments from 1.
- In RUN, raise finish bits 0001, 0010, 0100, 1000 on successive cycles, fail=0 -> done=1 one cycle after the last, pass=1, fail=0, finish_mask=1111, cycles=4.
- Finish all at cycle 5 with test_fail=0100 pulsed 1 cycle at cycle 3 -> done=1, fail=1, pass=0, fail_mask=0100 (no FAIL_FAST_EN).
- TIMEOUT=16, only harness 0 finishes -> done=1 after 16 RUN cycles, timeout=1, fail=1, finish_mask=0001.
- TIMEOUT=16, all finish on RUN cycle 16 -> timeout=0, pass=1.
- Mid-RUN reset low 1 cycle -> all outputs back to reset values, HOLD re-runs.
- With FAIL_FAST_EN: test_fail=0010 at RUN cycle 2 -> done=1 next cycle, fail_mask=0010, finish_mask unchanged.

Source files
------------

// File: rtl/test_status_collector.sv
// -----------------------------------------------------------------------------
// test_status_collector
//
// Consumer end of the per-test fail/finish interface exposed by every
// self-checking harness. Holds the harnesses in reset for RESET_CYCLES,
// lets them run while collecting sticky fail/finish flags and counting
// cycles, and latches a single pass/fail/timeout verdict.
//
// Optional feature macro: FAIL_FAST_EN
//   defined   : any nonzero test_fail during RUN ends the run on that cycle
//   undefined : failures only accumulate; the run ends on completion/watchdog
//
// Ports:
//   clock        in   system clock, all logic on posedge
//   reset        in   synchronous active-low reset
//   test_fail    in   [NUM_TESTS] fail outputs of the harnesses
//   test_finish  in   [NUM_TESTS] finish outputs of the harnesses
//   test_reset   out  active-high reset to all harnesses
//   done         out  verdict valid, sticky until reset
//   pass         out  done and no failure and no timeout
//   fail         out  any harness failed, or timeout
//   timeout      out  watchdog fired before all harnesses finished
//   fail_mask    out  [NUM_TESTS] sticky per-harness fail bits
//   finish_mask  out  [NUM_TESTS] sticky per-harness finish bits
//   cycles       out  [CW] RUN cycles elapsed, saturating
// -----------------------------------------------------------------------------
module test_status_collector #(
    parameter int NUM_TESTS    = 4,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 1024,
    parameter int CW           = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_TESTS-1:0] test_fail,
    input  logic [NUM_TESTS-1:0] test_finish,
    output logic                 test_reset,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] finish_mask,
    output logic [CW-1:0]        cycles
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int                   HW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0]        HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]        WDOG_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]        CYC_MAX   = {CW{1'b1}};
    localparam logic [NUM_TESTS-1:0] ALL_FIN   = {NUM_TESTS{1'b1}};

    state_t               state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 test_reset_q, test_reset_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_TESTS-1:0] fail_mask_q, fail_mask_d;
    logic [NUM_TESTS-1:0] finish_mask_q, finish_mask_d;
    logic [CW-1:0]        cycles_q, cycles_d;

    // Completion and fail-fast look at the masks as they will be after this
    // cycle, so a flag arriving now counts immediately.
    logic [NUM_TESTS-1:0] fail_mask_upd_s;
    logic [NUM_TESTS-1:0] finish_mask_upd_s;
    logic                 complete_s;
    logic                 wdog_s;
    logic                 fail_fast_s;
    logic                 wdog_only_s;

    assign fail_mask_upd_s   = fail_mask_q | test_fail;
    assign finish_mask_upd_s = finish_mask_q | test_finish;
    assign complete_s        = (finish_mask_upd_s == ALL_FIN);
    assign wdog_s            = (cycles_q == WDOG_LAST);
`ifdef FAIL_FAST_EN
    assign fail_fast_s       = |test_fail;
`else
    assign fail_fast_s       = 1'b0;
`endif
    // Watchdog only reports a timeout when nothing of higher priority ends the run.
    assign wdog_only_s       = wdog_s & ~complete_s & ~fail_fast_s;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_HOLD;
            hold_q        <= {HW{1'b0}};
            test_reset_q  <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_mask_q   <= {NUM_TESTS{1'b0}};
            finish_mask_q <= {NUM_TESTS{1'b0}};
            cycles_q      <= {CW{1'b0}};
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            test_reset_q  <= test_reset_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            fail_mask_q   <= fail_mask_d;
            finish_mask_q <= finish_mask_d;
            cycles_q      <= cycles_d;
        end
    end

    // Next-state selection for the HOLD -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (fail_fast_s || complete_s || wdog_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_HOLD;
        endcase
    end

    // Next values of the registered outputs; everything holds unless updated.
    always_comb begin
        hold_d        = hold_q;
        test_reset_d  = test_reset_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        fail_mask_d   = fail_mask_q;
        finish_mask_d = finish_mask_q;
        cycles_d      = cycles_q;
        case (state_q)
            ST_HOLD: begin
                hold_d       = hold_q + HW'(1);
                // Release the harnesses so the first RUN cycle sees them out of reset.
                test_reset_d = (state_d == ST_HOLD) ? 1'b1 : 1'b0;
            end
            ST_RUN: begin
                fail_mask_d   = fail_mask_upd_s;
                finish_mask_d = finish_mask_upd_s;
                cycles_d      = (cycles_q == CYC_MAX) ? cycles_q : (cycles_q + CW'(1));
                if (state_d == ST_DONE) begin
                    done_d       = 1'b1;
                    test_reset_d = 1'b1;
                    timeout_d    = wdog_only_s;
                    fail_d       = (|fail_mask_upd_s) | wdog_only_s;
                    pass_d       = ~((|fail_mask_upd_s) | wdog_only_s);
                end else begin
                    done_d       = 1'b0;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign test_reset  = test_reset_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign fail_mask   = fail_mask_q;
    assign finish_mask = finish_mask_q;
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_test_status_collector.sv
// -----------------------------------------------------------------------------
// Self-checking bench for test_status_collector (NUM_TESTS=4, RESET_CYCLES=2,
// TIMEOUT=16). A behavioural model advances on every posedge from the same
// inputs; a compare process checks all outputs on every negedge. Directed
// scenarios add literal expectations, then randomized runs follow.
// -----------------------------------------------------------------------------
module tb_test_status_collector;

    localparam int NT   = 4;
    localparam int RC   = 2;
    localparam int TO   = 16;
    localparam int CWID = 32;

    logic            clock;
    logic            reset;
    logic [NT-1:0]   test_fail;
    logic [NT-1:0]   test_finish;
    logic            test_reset;
    logic            done;
    logic            pass;
    logic            fail;
    logic            timeout;
    logic [NT-1:0]   fail_mask;
    logic [NT-1:0]   finish_mask;
    logic [CWID-1:0] cycles;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    test_status_collector #(
        .NUM_TESTS   (NT),
        .RESET_CYCLES(RC),
        .TIMEOUT     (TO),
        .CW          (CWID)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .test_fail  (test_fail),
        .test_finish(test_finish),
        .test_reset (test_reset),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .fail_mask  (fail_mask),
        .finish_mask(finish_mask),
        .cycles     (cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: t = posedges since reset released (capped once running),
    // sticky masks, cycle count and the verdict.
    typedef struct {
        int              t;
        logic [NT-1:0]   fm;
        logic [NT-1:0]   fn;
        logic [CWID-1:0] cyc;
        bit              dn;
        bit              to;
    } model_t;

    model_t m;

    function automatic model_t step(input model_t s, input logic r,
                                    input logic [NT-1:0] f, input logic [NT-1:0] fi);
        model_t n;
        n = s;
        if (!r) begin
            n.t = 0; n.fm = '0; n.fn = '0; n.cyc = '0; n.dn = 1'b0; n.to = 1'b0;
        end else if (s.dn) begin
            n = s;
        end else if (s.t < RC) begin
            n.t = s.t + 1;
        end else begin
            n.fm = s.fm | f;
            n.fn = s.fn | fi;
            if (s.cyc != {CWID{1'b1}}) n.cyc = s.cyc + 1;
`ifdef FAIL_FAST_EN
            if (f != '0) begin
                n.dn = 1'b1; n.to = 1'b0;
            end else
`endif
            if (n.fn == {NT{1'b1}}) begin
                n.dn = 1'b1; n.to = 1'b0;
            end else if (n.cyc == CWID'(TO)) begin
                n.dn = 1'b1; n.to = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clock) begin
        m <= step(m, reset, test_fail, test_finish);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every cycle once the model has seen a reset.
    always @(negedge clock) begin
        if (chk_en) begin
            logic exp_fail;
            exp_fail = m.dn && ((m.fm != '0) || m.to);
            chk("test_reset",  64'(test_reset),  64'(m.dn || (m.t < RC)));
            chk("done",        64'(done),        64'(m.dn));
            chk("fail",        64'(fail),        64'(exp_fail));
            chk("pass",        64'(pass),        64'(m.dn && !exp_fail));
            chk("timeout",     64'(timeout),     64'(m.dn && m.to));
            chk("fail_mask",   64'(fail_mask),   64'(m.fm));
            chk("finish_mask", 64'(finish_mask), 64'(m.fn));
            chk("cycles",      64'(cycles),      64'(m.cyc));
        end
    end

    task automatic drive(input logic r, input logic [NT-1:0] f, input logic [NT-1:0] fi);
        @(negedge clock);
        reset = r; test_fail = f; test_finish = fi;
    endtask

    // Sample just after the edge that consumed the last drive.
    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    // Reset for n cycles, then walk through HOLD; next drive is RUN cycle 1.
    task automatic start_run(input int n);
        repeat (n) drive(1'b0, '0, '0);
        repeat (RC) drive(1'b1, '0, '0);
    endtask

    initial begin
        reset = 1'b0; test_fail = '0; test_finish = '0;

        // Reset and HOLD sequencing.
        repeat (3) drive(1'b0, '0, '0);
        settle();
        chk_en = 1'b1;
        chk("rst_test_reset", 64'(test_reset), 64'd1);
        chk("rst_done",       64'(done),       64'd0);
        chk("rst_cycles",     64'(cycles),     64'd0);
        drive(1'b1, '0, '0);
        settle();
        chk("hold1_test_reset", 64'(test_reset), 64'd1);
        drive(1'b1, '0, '0);
        settle();
        chk("hold2_test_reset", 64'(test_reset), 64'd0);
        drive(1'b1, '0, '0);
        settle();
        chk("run1_cycles", 64'(cycles), 64'd1);
        chk("run1_done",   64'(done),   64'd0);

        // Successive finishes, no failures.
        start_run(3);
        drive(1'b1, 4'b0000, 4'b0001);
        drive(1'b1, 4'b0000, 4'b0010);
        drive(1'b1, 4'b0000, 4'b0100);
        settle();
        chk("seq_done_early", 64'(done), 64'd0);
        drive(1'b1, 4'b0000, 4'b1000);
        settle();
        chk("seq_done",   64'(done),        64'd1);
        chk("seq_pass",   64'(pass),        64'd1);
        chk("seq_fail",   64'(fail),        64'd0);
        chk("seq_fmask",  64'(finish_mask), 64'hF);
        chk("seq_cycles", 64'(cycles),      64'd4);

        // Fail pulse at RUN cycle 3, all finish at cycle 5.
        start_run(1);
        for (int k = 1; k <= 5; k++)
            drive(1'b1, (k == 3) ? 4'b0100 : 4'b0000, (k == 5) ? 4'b1111 : 4'b0000);
        settle();
        chk("fp_done",  64'(done),      64'd1);
        chk("fp_fail",  64'(fail),      64'd1);
        chk("fp_pass",  64'(pass),      64'd0);
        chk("fp_failm", 64'(fail_mask), 64'b0100);
`ifdef FAIL_FAST_EN
        chk("fp_cycles", 64'(cycles),      64'd3);
        chk("fp_finm",   64'(finish_mask), 64'b0000);
`else
        chk("fp_cycles", 64'(cycles),      64'd5);
        chk("fp_finm",   64'(finish_mask), 64'b1111);
`endif

        // Fail at RUN cycle 2 after harness 0 finished.
        start_run(1);
        drive(1'b1, 4'b0000, 4'b0001);
        drive(1'b1, 4'b0010, 4'b0000);
        settle();
`ifdef FAIL_FAST_EN
        chk("ff_done",  64'(done),        64'd1);
        chk("ff_to",    64'(timeout),     64'd0);
`else
        chk("ff_done",  64'(done),        64'd0);
`endif
        chk("ff_failm", 64'(fail_mask),   64'b0010);
        chk("ff_finm",  64'(finish_mask), 64'b0001);

        // Watchdog: only harness 0 finishes.
        start_run(1);
        drive(1'b1, '0, 4'b0001);
        repeat (TO - 2) drive(1'b1, '0, '0);
        settle();
        chk("wd_not_yet", 64'(done), 64'd0);
        drive(1'b1, '0, '0);
        settle();
        chk("wd_done",    64'(done),        64'd1);
        chk("wd_timeout", 64'(timeout),     64'd1);
        chk("wd_fail",    64'(fail),        64'd1);
        chk("wd_finm",    64'(finish_mask), 64'b0001);
        chk("wd_cycles",  64'(cycles),      64'd16);

        // Completion coincides with watchdog: completion wins.
        start_run(1);
        repeat (TO - 1) drive(1'b1, '0, '0);
        drive(1'b1, '0, 4'b1111);
        settle();
        chk("co_done",    64'(done),    64'd1);
        chk("co_timeout", 64'(timeout), 64'd0);
        chk("co_pass",    64'(pass),    64'd1);

        // Mid-RUN reset for one cycle.
        start_run(1);
        drive(1'b1, 4'b0001, 4'b0011);
        drive(1'b1, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000);
        settle();
        chk("mr_test_reset", 64'(test_reset),  64'd1);
        chk("mr_failm",      64'(fail_mask),   64'd0);
        chk("mr_finm",       64'(finish_mask), 64'd0);
        chk("mr_cycles",     64'(cycles),      64'd0);
        repeat (RC) drive(1'b1, '0, '0);
        settle();
        chk("mr_rerun", 64'(test_reset), 64'd0);

        // Randomized runs, including activity in HOLD/DONE and stray resets.
        for (int it = 0; it < 30; it++) begin
            start_run(int'($urandom_range(1, 3)));
            for (int c = 0; c < 24; c++) begin
                logic [NT-1:0] f, fi;
                logic r;
                f  = ($urandom_range(0, 9) == 0) ? NT'($urandom) : '0;
                fi = ($urandom_range(0, 2) == 0) ? NT'($urandom) : '0;
                r  = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
                drive(r, f, fi);
            end
        end

        drive(1'b1, '0, '0);
        settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
